// File: rtl/inst_encoder.sv
// Two-stage instruction encoder: one-hot select plus operand fields in, packed
// 32-bit instruction word with a sequential write address out.
`timescale 1ns/1ps
module inst_encoder #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:63]   in_inst,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_word,
  output logic [AW-1:0] out_addr,
  input  logic          addr_clr,
  output logic          err_pulse,
  output logic [7:0]    err_count
);

  localparam int unsigned NSEL = 64;
  localparam int unsigned IW   = 6;

  logic            s1_valid;
  logic [NSEL-1:0] s1_inst;
  logic [4:0]      s1_rs;
  logic [4:0]      s1_rt;
  logic [4:0]      s1_rd;
  logic [15:0]     s1_imm;

  logic            s1_adv;
  logic            legal;
  logic [IW-1:0]   idx;
  logic [31:0]     enc_word;

  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || s1_adv);

  // One-hot legality, set-bit index and field packing for the S1 entry
  always_comb begin
    idx   = '0;
    legal = (s1_inst != '0) && ((s1_inst & (s1_inst - NSEL'(1))) == '0);
    for (int i = 0; i < NSEL; i++) begin
      if (s1_inst[i]) idx = IW'(i);
    end
    if (idx[IW-1]) enc_word = {idx, s1_rs, s1_rt, s1_imm};
    else           enc_word = {6'b0, s1_rs, s1_rt, s1_rd, 5'b0, idx};
  end

  // S1 input register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_inst  <= '0;
      s1_rs    <= '0;
      s1_rt    <= '0;
      s1_rd    <= '0;
      s1_imm   <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      for (int i = 0; i < NSEL; i++) s1_inst[i] <= in_inst[i];
      s1_rs    <= in_rs;
      s1_rt    <= in_rt;
      s1_rd    <= in_rd;
      s1_imm   <= in_imm;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 output register; an illegal entry drains S1 without producing a word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (s1_adv && legal) begin
      out_valid <= 1'b1;
      out_word  <= enc_word;
    end else if (s1_adv || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Dropped-select flag and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= s1_adv && !legal;
      if (s1_adv && !legal && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  // Write address: clear takes priority over the handshake increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         out_addr <= '0;
    else if (addr_clr)               out_addr <= '0;
    else if (out_valid && out_ready) out_addr <= out_addr + AW'(1);
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed beats push expected words, a
// negedge monitor pops and checks them against both an AW=10 and an AW=2 instance.
`timescale 1ns/1ps
module tb_inst_encoder;

  typedef struct {
    logic [31:0] word;
    int          addr;
    int          idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready2;
  logic [0:63] in_inst = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic        out_valid, out_valid2;
  logic        out_ready = 1'b1;
  logic [31:0] out_word, out_word2;
  logic [9:0]  out_addr;
  logic [1:0]  out_addr2;
  logic        addr_clr = 1'b0;
  logic        err_pulse, err_pulse2;
  logic [7:0]  err_count, err_count2;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int first_low;
  exp_t sb[$];
  exp_t e;
  logic        stall = 1'b0;
  logic [31:0] pw;
  logic [9:0]  pa;

  always #5 clk = ~clk;

  inst_encoder #(.AW(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
    .addr_clr(addr_clr), .err_pulse(err_pulse), .err_count(err_count));

  inst_encoder #(.AW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_inst(in_inst), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_word(out_word2), .out_addr(out_addr2),
    .addr_clr(addr_clr), .err_pulse(err_pulse2), .err_count(err_count2));

  function automatic logic [63:0] sel(input int i);
    return 64'(1) << i;
  endfunction

  // Instruction-decoder mapping: nonzero opcode is the index, else func is
  function automatic logic [63:0] decode(input logic [31:0] w);
    if (w[31:26] != 6'd0) return sel(int'(w[31:26]));
    return sel(int'(w[5:0]));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [63:0] s, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input bit legal,
                      input logic [31:0] word, input int addr);
    exp_t x;
    bit   got = 1'b0;
    x.word = word; x.addr = addr; x.idx = 0;
    for (int k = 0; k < 64; k++) begin
      in_inst[k] = s[k];
      if (s[k]) x.idx = k;
    end
    in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    in_valid = 1'b1;
    if (legal) sb.push_back(x);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (got) n_acc++;
    else begin
      checks++; errors++;
      $display("FAIL accept_timeout: beat not accepted within 200 cycles at %0t", $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    sb.delete();
    in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Scoreboard monitor: handshake compare, decode round-trip, stall stability
  always @(negedge clk) begin
    if (rst) begin
      stall <= 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_word", 64'(out_word), 64'(pw));
        chk("stall_addr", 64'(out_addr), 64'(pa));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got word 0x%08h addr %0d with nothing expected", out_word, out_addr);
        end else begin
          e = sb.pop_front();
          chk("word", 64'(out_word), 64'(e.word));
          chk("addr", 64'(out_addr), 64'(e.addr % 1024));
          chk("word_aw2", 64'(out_word2), 64'(e.word));
          chk("addr_aw2", 64'(out_addr2), 64'(e.addr % 4));
          chk("decode", decode(out_word), sel(e.idx));
        end
      end
      stall <= out_valid && !out_ready;
      pw    <= out_word;
      pa    <= out_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_word", 64'(out_word), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    chk("rst_err_pulse", 64'(err_pulse), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1 chk("rel_in_ready", 64'(in_ready), 64'd1);
    idle(1);

    // R-type with latency check, then sequential address
    send(sel(5), 5'd3, 5'd4, 5'd7, 16'hFFFF, 1'b1, 32'h00643805, 0);
    @(negedge clk); chk("latency_n", 64'(out_valid), 64'd0);
    @(negedge clk); chk("latency_n1", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    send(sel(0), 5'd31, 5'd0, 5'd1, 16'h0000, 1'b1, 32'h03E00800, 1);
    // I-type and boundary indices, back to back
    send(sel(35), 5'd1, 5'd2, 5'd31, 16'h0010, 1'b1, 32'h8C220010, 2);
    send(sel(63), 5'd0, 5'd31, 5'd0, 16'hFFFF, 1'b1, 32'hFC1FFFFF, 3);
    send(sel(31), 5'd0, 5'd0, 5'd31, 16'h0000, 1'b1, 32'h0000F81F, 4);
    idle(5);

    // Illegal selects
    do_reset();
    send(sel(3) | sel(40), 5'd1, 5'd1, 5'd1, 16'h1, 1'b0, 32'h0, 0);
    send(64'd0, 5'd1, 5'd1, 5'd1, 16'h1, 1'b0, 32'h0, 0);
    @(negedge clk); chk("err_pulse_1", 64'(err_pulse), 64'd1);
    @(negedge clk); chk("err_pulse_2", 64'(err_pulse), 64'd1);
    @(negedge clk); chk("err_pulse_end", 64'(err_pulse), 64'd0);
    chk("err_count_2", 64'(err_count), 64'd2);
    @(posedge clk); #1;
    send(sel(5), 5'd3, 5'd4, 5'd7, 16'h0, 1'b1, 32'h00643805, 0);
    for (int i = 0; i < 300; i++)
      send((i % 2 == 0) ? 64'd0 : ~64'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 32'h0, 0);
    idle(4);
    chk("err_count_sat", 64'(err_count), 64'd255);
    chk("err_count_sat_aw2", 64'(err_count2), 64'd255);
    send(sel(1), 5'd1, 5'd1, 5'd1, 16'h0, 1'b1, 32'h00210801, 1);
    idle(5);

    // Backpressure: 4 beats with out_ready low for 5 cycles
    do_reset();
    out_ready = 1'b0;
    n_acc = 0;
    first_low = -1;
    fork
      begin
        send(sel(1), 5'd1, 5'd1, 5'd1, 16'h0, 1'b1, 32'h00210801, 0);
        send(sel(2), 5'd2, 5'd2, 5'd2, 16'h0, 1'b1, 32'h00421002, 1);
        send(sel(33), 5'd3, 5'd3, 5'd0, 16'h1234, 1'b1, 32'h84631234, 2);
        send(sel(62), 5'd4, 5'd5, 5'd0, 16'hABCD, 1'b1, 32'hF885ABCD, 3);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (!in_ready && first_low < 0) first_low = n_acc;
        end
      end
    join
    chk("ready_fall_accepts", 64'(first_low), 64'd2);
    idle(5);

    // Wrap: five words
    do_reset();
    send(sel(5), 5'd3, 5'd4, 5'd7, 16'h0, 1'b1, 32'h00643805, 0);
    send(sel(0), 5'd31, 5'd0, 5'd1, 16'h0, 1'b1, 32'h03E00800, 1);
    send(sel(35), 5'd1, 5'd2, 5'd0, 16'h0010, 1'b1, 32'h8C220010, 2);
    send(sel(63), 5'd0, 5'd31, 5'd0, 16'hFFFF, 1'b1, 32'hFC1FFFFF, 3);
    send(sel(31), 5'd0, 5'd0, 5'd31, 16'h0, 1'b1, 32'h0000F81F, 4);
    idle(5);

    // Clear coinciding with the handshake at address 2
    do_reset();
    send(sel(1), 5'd1, 5'd1, 5'd1, 16'h0, 1'b1, 32'h00210801, 0);
    send(sel(2), 5'd2, 5'd2, 5'd2, 16'h0, 1'b1, 32'h00421002, 1);
    idle(4);
    out_ready = 1'b0;
    send(sel(33), 5'd3, 5'd3, 5'd0, 16'h1234, 1'b1, 32'h84631234, 2);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    @(posedge clk); #1;
    out_ready = 1'b1; addr_clr = 1'b1;
    @(posedge clk); #1;
    addr_clr = 1'b0;
    chk("addr_after_clr", 64'(out_addr), 64'd0);
    send(sel(62), 5'd4, 5'd5, 5'd0, 16'hABCD, 1'b1, 32'hF885ABCD, 0);
    idle(5);

    // Reset with both stages full and err_count = 3
    do_reset();
    for (int i = 0; i < 3; i++) send(64'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 32'h0, 0);
    send(sel(5), 5'd3, 5'd4, 5'd7, 16'h0, 1'b1, 32'h00643805, 0);
    idle(4);
    chk("err_count_3", 64'(err_count), 64'd3);
    out_ready = 1'b0;
    send(sel(1), 5'd1, 5'd1, 5'd1, 16'h0, 1'b1, 32'h00210801, 1);
    send(sel(2), 5'd2, 5'd2, 5'd2, 16'h0, 1'b1, 32'h00421002, 2);
    @(posedge clk); #3;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_word", 64'(out_word), 64'd0);
    chk("mid_rst_addr", 64'(out_addr), 64'd0);
    chk("mid_rst_err_pulse", 64'(err_pulse), 64'd0);
    chk("mid_rst_err_count", 64'(err_count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_aw2", {out_valid2, err_pulse2, in_ready2, err_count2, out_word2}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    send(sel(35), 5'd1, 5'd2, 5'd0, 16'h0010, 1'b1, 32'h8C220010, 0);
    idle(5);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
